// File: rtl/shazam_audio_pkg.sv
// Shared constants and FSM encoding for the Shazam audio capture path.
package shazam_audio_pkg;

  localparam int CLK_HZ     = 50_000_000;
  localparam int SAMPLE_HZ  = 16_000;
  localparam int CLK_DIV    = CLK_HZ / SAMPLE_HZ;   // system clocks per sample
  localparam int SAMPLE_W   = 12;                   // ADC result width
  localparam int FRAME_LEN  = 256;                  // samples per frame, power of 2
  localparam int IDX_W      = $clog2(FRAME_LEN);
  localparam int ADC_OFFSET = 2048;                 // offset-binary midscale for SAMPLE_W=12

  // Capture FSM: wait for a sample slot, wait for the ADC, wait for RAM access.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2
  } cap_state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider: tick_o is high for one cycle every CLK_DIV clocks,
// in the cycle the counter sits at CLK_DIV-1.
module sample_tick_gen #(
  parameter int CLK_DIV = 3125
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wrap at CLK_DIV-1; the tick marks the last count of each period.
  always_comb begin
    tick_o = (cnt_q == CNT_LAST);
    cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);
  end

  // Counter register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/audio_frame_capture.sv
// Paces ADC conversions, converts offset-binary results to signed 16-bit and
// writes them into ping-pong frames of the Shazam sample RAM.
module audio_frame_capture #(
  parameter int CLK_DIV   = shazam_audio_pkg::CLK_DIV,
  parameter int SAMPLE_W  = shazam_audio_pkg::SAMPLE_W,
  parameter int FRAME_LEN = shazam_audio_pkg::FRAME_LEN,
  parameter int IDX_W     = shazam_audio_pkg::IDX_W
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [4:0]          channel,
  input  logic                can_write_ram,
  output logic                adc_req,
  output logic [4:0]          adc_channel,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic                ram_we,
  output logic [IDX_W:0]      ram_addr,
  output logic [15:0]         ram_wdata,
  output logic                frame_ready,
  output logic                frame_bank,
  output logic                overrun
);

  import shazam_audio_pkg::*;

  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [SAMPLE_W-1:0] MIDSCALE = SAMPLE_W'(2 ** (SAMPLE_W - 1));

  cap_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              bank_q, bank_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [4:0]        chan_q, chan_d;
  logic              frame_ready_q, frame_ready_d;
  logic              frame_bank_q, frame_bank_d;
  logic              overrun_q, overrun_d;
  logic              tick;
  logic [SAMPLE_W-1:0] sample_s;

  sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (CLOCK),
    .rst_n  (RESET),
    .tick_o (tick)
  );

  // Flipping the MSB turns offset-binary into two's complement.
  always_comb sample_s = adc_data ^ MIDSCALE;

  // Next-state and strobe outputs of the capture FSM.
  // NOTE: every output gets a default before the case so no path can leave a
  // value unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    bank_d        = bank_q;
    wdata_d       = wdata_q;
    chan_d        = chan_q;
    frame_ready_d = 1'b0;
    frame_bank_d  = frame_bank_q;
    overrun_d     = overrun_q | (tick && (state_q != ST_IDLE));
    adc_req       = 1'b0;
    ram_we        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          adc_req = 1'b1;
          state_d = ST_REQ;
          // Channel is fixed for a whole frame, sampled at its first request.
          if (idx_q == '0) chan_d = channel;
        end
      end
      ST_REQ: begin
        if (adc_valid) begin
          wdata_d = {{(16 - SAMPLE_W){sample_s[SAMPLE_W-1]}}, sample_s};
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (can_write_ram) begin
          ram_we  = 1'b1;
          state_d = ST_IDLE;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            idx_d         = '0;
            bank_d        = ~bank_q;
            frame_ready_d = 1'b1;
            frame_bank_d  = bank_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The channel in force for the request is visible alongside adc_req.
    adc_channel = chan_d;
  end

  // State, frame position, sample and status registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      bank_q        <= 1'b0;
      wdata_q       <= '0;
      chan_q        <= '0;
      frame_ready_q <= 1'b0;
      frame_bank_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      bank_q        <= bank_d;
      wdata_q       <= wdata_d;
      chan_q        <= chan_d;
      frame_ready_q <= frame_ready_d;
      frame_bank_q  <= frame_bank_d;
      overrun_q     <= overrun_d;
    end
  end

  assign ram_addr    = {bank_q, idx_q};
  assign ram_wdata   = wdata_q;
  assign frame_ready = frame_ready_q;
  assign frame_bank  = frame_bank_q;
  assign overrun     = overrun_q;

endmodule
